// File: rtl/event_seq_pkg.sv
// Shared types for the event sequencer: FSM state, queued command record, widths.
package event_seq_pkg;

  localparam int TS_W           = 32;
  localparam int NUM_EVENTS_DEF = 5;
  localparam int DELAY_W_DEF    = 16;

  function automatic int id_width(input int num_events);
    return (num_events > 1) ? $clog2(num_events) : 1;
  endfunction

  localparam int ID_W_DEF = id_width(NUM_EVENTS_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Command record sized from the package defaults; the top's parameters default to the same values.
  typedef struct packed {
    logic [ID_W_DEF-1:0]    id;
    logic [DELAY_W_DEF-1:0] delay;
  } cmd_t;

endpackage

// File: rtl/event_seq_fifo.sv
// Synchronous command FIFO with flush; no bypass, so a push into an empty FIFO is visible next cycle.
module event_seq_fifo
  import event_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  cmd_t                   wr_dat_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output cmd_t                   rd_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  cmd_t           mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           push_ok;
  logic           pop_ok;

  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign count_o  = cnt_q;
  assign rd_dat_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only slots covered by cnt_q are ever read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/event_sequencer.sv
// Replays queued (delay, id) commands as one-cycle strobes on ev_pulse after a start strobe.
// Optional EVENT_SEQ_TIMESTAMP_EN adds a free-running cycle counter and last_ts/last_id capture.
module event_sequencer
  import event_seq_pkg::*;
#(
  parameter  int NUM_EVENTS = NUM_EVENTS_DEF,
  parameter  int DELAY_W    = DELAY_W_DEF,
  parameter  int DEPTH      = 4,
  localparam int ID_W       = id_width(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DELAY_W-1:0]    cmd_delay,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic [NUM_EVENTS-1:0] ev_pulse,
  output logic                  done,
  output logic                  err
`ifdef EVENT_SEQ_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]       last_ts,
  output logic [ID_W-1:0]       last_id
`endif
);

  localparam int          CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [31:0] NUM_EV_U32 = NUM_EVENTS;

  state_e                  state_q, state_d;
  logic [DELAY_W-1:0]      cnt_q, cnt_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [NUM_EVENTS-1:0]   pulse_q, pulse_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  cmd_t                    push_dat;
  cmd_t                    head;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty_nxt;
  logic [DELAY_W-1:0]      head_delay;
  logic                    fire;
  logic                    id_oob;
  logic                    start_empty;

  assign push_dat.id    = cmd_id;
  assign push_dat.delay = cmd_delay;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full && !abort;

  event_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (fifo_push),
    .wr_dat_i (push_dat),
    .pop_i    (fifo_pop),
    .flush_i  (abort),
    .rd_dat_o (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign head_delay = (head.delay == '0) ? DELAY_W'(1) : head.delay;
  assign fire       = (state_q == RUN) && (cnt_q == DELAY_W'(1));
  assign id_oob     = (32'(id_q) >= NUM_EV_U32);

  // FIFO occupancy as seen next cycle; lets the registered done line up with the last pulse.
  assign fifo_empty_nxt = !fifo_push &&
                          ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    fifo_pop    = 1'b0;
    start_empty = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = RUN;
              cnt_d    = head_delay;
              id_d     = head.id;
            end else begin
              start_empty = 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt_q == DELAY_W'(1)) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              cnt_d    = head_delay;
              id_d     = head.id;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from next state so the strobe lands in the cycle the counter reads 1.
  always_comb begin
    pulse_d = '0;
    done_d  = 1'b0;
    if (!abort) begin
      if ((state_d == RUN) && (cnt_d == DELAY_W'(1))) begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
          pulse_d[i] = (id_d == ID_W'(i));
        end
        done_d = fifo_empty_nxt;
      end
      if (start_empty) done_d = 1'b1;
    end
  end

  assign err_d = err_q || (fire && id_oob);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      pulse_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign ev_pulse = pulse_q;
  assign done     = done_q;
  assign err      = err_q;

`ifdef EVENT_SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] last_ts_q, last_ts_d;
  logic [ID_W-1:0] last_id_q, last_id_d;

  // Every consumed slot is stamped, including out-of-range ids that raise no strobe.
  always_comb begin
    ts_d      = ts_q + 1'b1;
    last_ts_d = last_ts_q;
    last_id_d = last_id_q;
    if (fire) begin
      last_ts_d = ts_q;
      last_id_d = id_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q      <= '0;
      last_ts_q <= '0;
      last_id_q <= '0;
    end else begin
      ts_q      <= ts_d;
      last_ts_q <= last_ts_d;
      last_id_q <= last_id_d;
    end
  end

  assign last_ts = last_ts_q;
  assign last_id = last_id_q;
`endif

endmodule

// File: doc/event_sequencer.md
Name: event_sequencer

Overview:
- Synthesizable stimulus-side stage that fires named events as one-cycle strobes on a bank of event lines.
- Fires on a programmed schedule of relative delays, measured in cycles since the previous event.
- Commands are queued through a valid/ready port into a small FIFO, then replayed after a start strobe.
- Sits directly upstream of event-observer/monitor logic, which consumes the ev_pulse lines.

Parameters:
- NUM_EVENTS, 5: number of event lines.
- DELAY_W, 16: width of the per-command relative delay.
- DEPTH, 4: command FIFO depth; power of 2, at least 2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- cmd_valid, input, 1: a command is presented.
- cmd_ready, output, 1: FIFO can accept; equals !full.
- cmd_delay, input, DELAY_W: cycles since the previous event (or since start) before firing.
- cmd_id, input, ID_W = $clog2(NUM_EVENTS): which event line to fire.
- start, input, 1: begin replaying queued commands.
- abort, input, 1: flush the queue and stop.
- busy, output, 1: sequencer is running.
- ev_pulse, output, NUM_EVENTS: one-hot, one-cycle event strobes.
- done, output, 1: one-cycle pulse on normal completion.
- err, output, 1: sticky flag for an out-of-range cmd_id.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; state IDLE; counter 0.
  - ev_pulse=0, done=0, busy=0, err=0; cmd_ready=1.
- Push:
  - A command is accepted when cmd_valid && cmd_ready at the clock edge.
  - Pushes are allowed in any state, including while running.
  - There is no bypass path: a push in the same cycle as a pop to/from empty lands next cycle.
- FSM states: IDLE, RUN.
- IDLE:
  - start with FIFO non-empty: pop the head, load counter = max(delay,1), go to RUN. busy=1 from the next cycle.
  - start with FIFO empty: done pulses the next cycle; stay IDLE.
- RUN:
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, ev_pulse[id] is asserted for exactly that cycle.
  - If the FIFO is non-empty in that same cycle: pop the next entry and reload the counter with max(delay,1). There are no gap cycles.
  - If the FIFO is empty in that cycle: done is asserted in the same cycle as the last ev_pulse, and the next state is IDLE.
- Timing rule:
  - The first event fires max(D0,1) cycles after the cycle in which start is sampled.
  - Event k fires max(Dk,1) cycles after event k-1.
  - Delay 0 is treated as 1.
- Out-of-range cmd_id (id >= NUM_EVENTS):
  - No ev_pulse bit is asserted; the time slot is still consumed.
  - err is set and stays set until reset.
- start while RUN: ignored.
- abort (any state):
  - Next cycle: FIFO flushed, IDLE, counter 0. No done, no ev_pulse.
  - abort has priority over start, push, and fire in the same cycle.
  - The cmd_valid of an aborted push is dropped.
- Full FIFO: cmd_ready=0. A simultaneous pop frees a slot only from the next cycle.
- Reset mid-RUN: all outputs return to reset values immediately (asynchronous).
- ev_pulse and done are registered outputs.

Optional Feature:
- Macro: EVENT_SEQ_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter, reset to 0, and outputs last_ts[31:0] and last_id[ID_W-1:0].
  - On each ev_pulse (including out-of-range slots), these capture the counter value and id in the pulse cycle; they are visible the cycle after the pulse.
  - The counter wraps mod 2^32.
  - Reset value of last_ts and last_id is 0.
- Undefined: these ports and the counter are absent; all other behaviour is identical.

Decomposition:
- Package event_seq_pkg contains:
  - state enum {IDLE, RUN};
  - cmd_t packed struct {id, delay};
  - localparam helper for ID_W;
  - TS_W = 32.
- One sub-module, event_seq_fifo: synchronous FIFO of cmd_t with push/pop/flush, full/empty, and a count output.
- event_sequencer holds the FSM, delay counter, decode, and the optional timestamp logic.

Test Plan:
- Push (20,id0), (30,id0), (50,id0), (10,id3); start at cycle T:
  - ev_pulse[0] at T+20, T+50, T+100;
  - ev_pulse[3] at T+110 with done in the same cycle;
  - busy from T+1 to T+110; err=0.
- Push (0,id1), (0,id2); start at T: ev_pulse[1] at T+1, ev_pulse[2] at T+2, done at T+2.
- Push 4 commands with DEPTH=4:
  - cmd_ready=0; a 5th cmd_valid is held, not lost.
  - After start, the first pop raises cmd_ready the next cycle, and the 5th command is accepted and fires last.
- Push (5,id7) with NUM_EVENTS=5; start at T:
  - no ev_pulse bit at T+5;
  - err=1 from T+6 and held;
  - done at T+5.
- Push (100,id2); start; abort at T+40:
  - no ev_pulse or done ever;
  - IDLE at T+41; FIFO empty.
  - A subsequent start gives done only, one cycle later.
- Reset asserted mid-RUN (async, between clock edges): outputs clear immediately. With EVENT_SEQ_TIMESTAMP_EN, last_ts=0 after reset, and on a rerun it matches the pulse cycles.
